// File: rtl/im_pkg.sv
// Shared types and helpers for the boot-loadable instruction memory.
// Holds the boot FSM encoding, default widths, NOP encoding and parity helper.
package im_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } im_state_e;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_INST_W = 16;

    localparam logic [15:0] NOP_ENC = 16'h0000;

    // Even parity: the stored bit makes the total count of ones even.
    // Zero-extension by the caller leaves the result unchanged.
    function automatic logic calc_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/im_bootload_ram.sv
// Single-write, single-registered-read instruction array for im_bootload.
// With IM_PARITY_EN defined, a parity column is stored and checked on read.
module im_bootload_ram
    import im_pkg::*;
#(
    parameter int INST_W = DEF_INST_W,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [INST_W-1:0] rdata,
    output logic              rd_par_err
);

    // No reset on the array or the read register so the tools can map both
    // onto a block RAM; the top masks rdata until a real fetch has happened.
    logic [INST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

`ifdef IM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            par_mem[waddr] <= calc_parity(64'(wdata));
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rd_par_err <= (calc_parity(64'(mem[raddr])) != par_mem[raddr]);
        end
    end
`else
    assign rd_par_err = 1'b0;
`endif

endmodule

// File: rtl/im_bootload.sv
// Instruction memory loaded at run time over a valid/ready boot port.
// Optional per-word parity checking is enabled by defining IM_PARITY_EN.
module im_bootload
    import im_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter int                DEPTH    = 1 << ADDR_W,
    parameter logic [INST_W-1:0] NOP_WORD = INST_W'(NOP_ENC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              ld_valid,
    input  logic [INST_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_err,
    output logic              boot_done,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic              par_err
);

    localparam int              MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MEM_AW-1:0] LAST_ADDR = MEM_AW'(DEPTH - 1);

    im_state_e         state, state_nxt;
    logic [MEM_AW-1:0] wptr;
    logic              handshake;
    logic              at_last_addr;
    logic              pc_in_range;
    logic              ram_re;
    logic              nop_sel;
    logic [INST_W-1:0] ram_rdata;
    logic              ram_par_err;

    assign handshake    = ld_valid & ld_ready;
    assign at_last_addr = (wptr == LAST_ADDR);
    assign pc_in_range  = ({1'b0, pc_in} < (ADDR_W + 1)'(DEPTH));
    assign ram_re       = (state == ST_READY) && fetch_en && pc_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (load_start) state_nxt = ST_LOAD;
            ST_LOAD:  if (handshake && (ld_last || at_last_addr)) state_nxt = ST_READY;
            ST_READY: if (load_start) state_nxt = ST_LOAD;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_ready  = 1'b0;
        boot_done = 1'b0;
        unique case (state)
            ST_LOAD:  ld_ready  = 1'b1;
            ST_READY: boot_done = 1'b1;
            default:  ;
        endcase
    end

    // A full array without ld_last is an overflow; the FSM leaves LOAD on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            ld_count <= '0;
            ld_err   <= 1'b0;
        end else if (load_start && (state != ST_LOAD)) begin
            wptr     <= '0;
            ld_count <= '0;
            ld_err   <= 1'b0;
        end else if (handshake) begin
            wptr     <= wptr + 1'b1;
            ld_count <= ld_count + 1'b1;
            if (!ld_last && at_last_addr) begin
                ld_err <= 1'b1;
            end
        end
    end

    // nop_sel masks the unreset RAM output whenever no in-range fetch is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nop_sel    <= 1'b1;
            inst_valid <= 1'b0;
        end else if (state != ST_READY) begin
            nop_sel    <= 1'b1;
            inst_valid <= 1'b0;
        end else if (fetch_en) begin
            nop_sel    <= !pc_in_range;
            inst_valid <= 1'b1;
        end
    end

    assign inst    = nop_sel ? NOP_WORD : ram_rdata;
    assign par_err = nop_sel ? 1'b0 : ram_par_err;

    im_bootload_ram #(
        .INST_W (INST_W),
        .DEPTH  (DEPTH),
        .AW     (MEM_AW)
    ) u_ram (
        .clk        (clk),
        .we         (handshake),
        .waddr      (wptr),
        .wdata      (ld_data),
        .re         (ram_re),
        .raddr      (pc_in[MEM_AW-1:0]),
        .rdata      (ram_rdata),
        .rd_par_err (ram_par_err)
    );

endmodule
